// File: rtl/frame_parser.sv
`default_nettype none
// ============================================================================
// Module      : frame_parser
// Description : Receive-side AXIS frame parser. Checks and strips the 16-byte
//               header (Dest, Src, Link_Type, SyncWord), forwards the payload
//               and keeps accept/drop statistics. Optional build macro:
//               FRAME_PARSER_PROMISC_EN (skip the destination address filter).
// Revision    : 1.0 - initial release
// ============================================================================
module frame_parser #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [DATA_WIDTH-1:0]   S_AXIS_tdata,
    input  logic [DATA_WIDTH/8-1:0] S_AXIS_tkeep,
    input  logic                    S_AXIS_tvalid,
    input  logic                    S_AXIS_tlast,
    output logic                    S_AXIS_tready,
    output logic [DATA_WIDTH-1:0]   M_AXIS_tdata,
    output logic [DATA_WIDTH/8-1:0] M_AXIS_tkeep,
    output logic                    M_AXIS_tvalid,
    output logic                    M_AXIS_tlast,
    input  logic                    M_AXIS_tready,
    input  logic [47:0]             Local_Address,
    input  logic [15:0]             Link_Type,
    input  logic [15:0]             SyncWord,
    input  logic [13:0]             Packet_Size,
    output logic [47:0]             Rx_Source_Address,
    output logic [13:0]             Rx_Length,
    output logic                    Rx_Done,
    output logic                    Rx_Length_Error,
    output logic [CNT_WIDTH-1:0]    Accept_Count,
    output logic [CNT_WIDTH-1:0]    Drop_Count
);

    localparam int          c_KEEP_W    = DATA_WIDTH / 8;
    localparam logic [47:0] c_BROADCAST = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        ST_HDR0    = 2'd0,
        ST_HDR1    = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DROP    = 2'd3
    } state_t;

    state_t                  r_state;
    logic [47:0]             r_dest;
    logic [47:0]             r_src;
    logic [13:0]             r_len_cnt;
    logic [13:0]             r_pend_len;
    logic [47:0]             r_pend_src;
    logic [DATA_WIDTH-1:0]   r_m_tdata;
    logic [c_KEEP_W-1:0]     r_m_tkeep;
    logic                    r_m_tvalid;
    logic                    r_m_tlast;
    logic [47:0]             r_rx_src;
    logic [13:0]             r_rx_len;
    logic                    r_rx_done;
    logic                    r_len_err;
    logic [CNT_WIDTH-1:0]    r_acc_cnt;
    logic [CNT_WIDTH-1:0]    r_drop_cnt;

    logic [63:0]             w_be;
    logic [3:0]              w_keep_cnt;
    logic                    w_s_ready;
    logic                    w_s_fire;
    logic                    w_m_fire;
    logic                    w_addr_ok;
    logic                    w_hdr_ok;
    logic                    w_drop_evt;
    logic                    w_acc_evt;

    // Byte-reverse the beat so header fields read big-endian (wire byte 0 = MSB).
    for (genvar gi = 0; gi < 8; gi++) begin : g_swap
        assign w_be[63-8*gi -: 8] = S_AXIS_tdata[8*gi +: 8];
    end

    always_comb begin
        w_keep_cnt = '0;
        for (int i = 0; i < c_KEEP_W; i++) begin
            w_keep_cnt = w_keep_cnt + {3'd0, S_AXIS_tkeep[i]};
        end
    end

    always_comb begin
        w_s_ready = 1'b0;
        if (!ARESET) begin
            if (r_state == ST_PAYLOAD) begin
                w_s_ready = !r_m_tvalid || M_AXIS_tready;
            end else begin
                w_s_ready = 1'b1;
            end
        end
    end

`ifdef FRAME_PARSER_PROMISC_EN
    logic w_unused_addr;
    assign w_unused_addr = ^{Local_Address, r_dest};
    assign w_addr_ok     = 1'b1;
`else
    assign w_addr_ok = (r_dest == Local_Address) || (r_dest == c_BROADCAST);
`endif

    assign w_s_fire   = S_AXIS_tvalid && w_s_ready;
    assign w_m_fire   = r_m_tvalid && M_AXIS_tready;
    assign w_hdr_ok   = w_addr_ok && (w_be[31:16] == Link_Type) && (w_be[15:0] == SyncWord);
    // Any tlast outside PAYLOAD ends a frame that will never be forwarded.
    assign w_drop_evt = w_s_fire && S_AXIS_tlast && (r_state != ST_PAYLOAD);
    assign w_acc_evt  = w_m_fire && r_m_tlast;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state    <= ST_HDR0;
            r_dest     <= '0;
            r_src      <= '0;
            r_len_cnt  <= '0;
            r_pend_len <= '0;
            r_pend_src <= '0;
            r_m_tdata  <= '0;
            r_m_tkeep  <= '0;
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
            r_rx_src   <= '0;
            r_rx_len   <= '0;
            r_rx_done  <= 1'b0;
            r_len_err  <= 1'b0;
            r_acc_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_rx_done <= 1'b0;
            r_len_err <= 1'b0;
            if (w_m_fire) begin
                r_m_tvalid <= 1'b0;
            end

            case (r_state)
                ST_HDR0: begin
                    if (w_s_fire) begin
                        r_dest        <= w_be[63:16];
                        r_src[47:32]  <= w_be[15:0];
                        if (!S_AXIS_tlast) begin
                            r_state <= ST_HDR1;
                        end
                    end
                end
                ST_HDR1: begin
                    if (w_s_fire) begin
                        r_src[31:0] <= w_be[63:32];
                        if (S_AXIS_tlast) begin
                            r_state <= ST_HDR0;
                        end else if (w_hdr_ok) begin
                            r_len_cnt <= '0;
                            r_state   <= ST_PAYLOAD;
                        end else begin
                            r_state <= ST_DROP;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (w_s_fire) begin
                        r_m_tdata  <= S_AXIS_tdata;
                        r_m_tkeep  <= S_AXIS_tkeep;
                        r_m_tlast  <= S_AXIS_tlast;
                        r_m_tvalid <= 1'b1;
                        if (S_AXIS_tlast) begin
                            // Snapshot frame results; the next header may overwrite r_src
                            // before this last beat leaves the output register.
                            r_pend_len <= r_len_cnt + {10'd0, w_keep_cnt};
                            r_pend_src <= r_src;
                            r_len_cnt  <= '0;
                            r_state    <= ST_HDR0;
                        end else begin
                            r_len_cnt <= r_len_cnt + {10'd0, w_keep_cnt};
                        end
                    end
                end
                ST_DROP: begin
                    if (w_s_fire && S_AXIS_tlast) begin
                        r_state <= ST_HDR0;
                    end
                end
                default: r_state <= ST_HDR0;
            endcase

            if (w_acc_evt) begin
                r_rx_done <= 1'b1;
                r_rx_len  <= r_pend_len;
                r_rx_src  <= r_pend_src;
                r_len_err <= (r_pend_len != Packet_Size);
                if (r_acc_cnt != '1) begin
                    r_acc_cnt <= r_acc_cnt + 1'b1;
                end
            end
            if (w_drop_evt && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    assign S_AXIS_tready     = w_s_ready;
    assign M_AXIS_tdata      = r_m_tdata;
    assign M_AXIS_tkeep      = r_m_tkeep;
    assign M_AXIS_tvalid     = r_m_tvalid;
    assign M_AXIS_tlast      = r_m_tlast;
    assign Rx_Source_Address = r_rx_src;
    assign Rx_Length         = r_rx_len;
    assign Rx_Done           = r_rx_done;
    assign Rx_Length_Error   = r_len_err;
    assign Accept_Count      = r_acc_cnt;
    assign Drop_Count        = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_frame_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_parser
// Description : Directed self-checking bench for frame_parser.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_parser;

    localparam logic [47:0] c_LOCAL = 48'h0A0B_0C0D_0E0F;
    localparam logic [47:0] c_OTHER = 48'h0A0B_0C0D_0E00;
    localparam logic [47:0] c_BCAST = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] c_SRC   = 48'h1122_3344_5566;
    localparam logic [15:0] c_TYPE  = 16'h88B5;
    localparam logic [15:0] c_SYNC  = 16'hA5A5;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [63:0] S_AXIS_tdata = '0;
    logic [7:0]  S_AXIS_tkeep = '0;
    logic        S_AXIS_tvalid = 1'b0;
    logic        S_AXIS_tlast = 1'b0;
    logic        S_AXIS_tready;
    logic [63:0] M_AXIS_tdata;
    logic [7:0]  M_AXIS_tkeep;
    logic        M_AXIS_tvalid;
    logic        M_AXIS_tlast;
    logic        M_AXIS_tready = 1'b1;
    logic [47:0] Local_Address = c_LOCAL;
    logic [15:0] Link_Type = c_TYPE;
    logic [15:0] SyncWord = c_SYNC;
    logic [13:0] Packet_Size = 14'd20;
    logic [47:0] Rx_Source_Address;
    logic [13:0] Rx_Length;
    logic        Rx_Done;
    logic        Rx_Length_Error;
    logic [15:0] Accept_Count;
    logic [15:0] Drop_Count;

    frame_parser #(.DATA_WIDTH(64), .CNT_WIDTH(16)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXIS_tdata(S_AXIS_tdata), .S_AXIS_tkeep(S_AXIS_tkeep),
        .S_AXIS_tvalid(S_AXIS_tvalid), .S_AXIS_tlast(S_AXIS_tlast),
        .S_AXIS_tready(S_AXIS_tready),
        .M_AXIS_tdata(M_AXIS_tdata), .M_AXIS_tkeep(M_AXIS_tkeep),
        .M_AXIS_tvalid(M_AXIS_tvalid), .M_AXIS_tlast(M_AXIS_tlast),
        .M_AXIS_tready(M_AXIS_tready),
        .Local_Address(Local_Address), .Link_Type(Link_Type),
        .SyncWord(SyncWord), .Packet_Size(Packet_Size),
        .Rx_Source_Address(Rx_Source_Address), .Rx_Length(Rx_Length),
        .Rx_Done(Rx_Done), .Rx_Length_Error(Rx_Length_Error),
        .Accept_Count(Accept_Count), .Drop_Count(Drop_Count)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_acc = 0;
    int exp_drop = 0;
    bit bp_mode = 1'b0;

    logic [63:0] out_data[$];
    logic [7:0]  out_keep[$];
    logic        out_last[$];
    int          out_cyc[$];
    int          in_cyc[$];
    int          done_cnt = 0;
    int          err_alone = 0;
    logic [13:0] last_len = '0;
    logic        last_err = 1'b0;
    logic [47:0] last_src = '0;
    bit          prev_hold = 1'b0;
    logic [73:0] prev_vec = '0;

    always @(posedge ACLK) cyc <= cyc + 1;

    always @(posedge ACLK) begin
        #1;
        M_AXIS_tready = bp_mode ? ~M_AXIS_tready : 1'b1;
    end

    // Output monitor: collects beats taken, Rx_Done results and checks hold stability.
    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (prev_hold) begin
                checks++;
                if ({M_AXIS_tdata, M_AXIS_tkeep, M_AXIS_tlast, M_AXIS_tvalid} !== prev_vec) begin
                    failures++;
                    $display("FAIL m_hold_stable: got %h required %h",
                             {M_AXIS_tdata, M_AXIS_tkeep, M_AXIS_tlast, M_AXIS_tvalid}, prev_vec);
                end
            end
            prev_hold = M_AXIS_tvalid && !M_AXIS_tready;
            prev_vec  = {M_AXIS_tdata, M_AXIS_tkeep, M_AXIS_tlast, 1'b1};
            if (M_AXIS_tvalid && M_AXIS_tready) begin
                out_data.push_back(M_AXIS_tdata);
                out_keep.push_back(M_AXIS_tkeep);
                out_last.push_back(M_AXIS_tlast);
                out_cyc.push_back(cyc);
            end
            if (Rx_Done) begin
                done_cnt++;
                last_len = Rx_Length;
                last_err = Rx_Length_Error;
                last_src = Rx_Source_Address;
            end
            if (Rx_Length_Error && !Rx_Done) err_alone++;
        end else begin
            prev_hold = 1'b0;
        end
    end

    function automatic logic [63:0] hdr0(input logic [47:0] dest, input logic [47:0] src);
        logic [63:0] r;
        for (int i = 0; i < 6; i++) r[8*i +: 8] = dest[47-8*i -: 8];
        r[55:48] = src[47:40];
        r[63:56] = src[39:32];
        return r;
    endfunction

    function automatic logic [63:0] hdr1(input logic [47:0] src, input logic [15:0] typ,
                                         input logic [15:0] sync);
        logic [63:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = src[31-8*i -: 8];
        r[39:32] = typ[15:8];
        r[47:40] = typ[7:0];
        r[55:48] = sync[15:8];
        r[63:56] = sync[7:0];
        return r;
    endfunction

    function automatic logic [63:0] pay(input int tag, input int idx);
        return {16'hD0D0, tag[15:0], 16'h5A00, idx[15:0]};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    task automatic clear_mon();
        out_data.delete(); out_keep.delete(); out_last.delete(); out_cyc.delete();
        in_cyc.delete();
        done_cnt = 0; err_alone = 0;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                             input bit payload);
        int n = 0;
        bit fired = 1'b0;
        S_AXIS_tdata = d; S_AXIS_tkeep = k; S_AXIS_tlast = l; S_AXIS_tvalid = 1'b1;
        while (!fired) begin
            @(negedge ACLK);
            if (payload) begin
                checks++;
                if (S_AXIS_tready !== (!M_AXIS_tvalid || M_AXIS_tready)) begin
                    failures++;
                    $display("FAIL s_tready_rule: got %b required %b", S_AXIS_tready,
                             (!M_AXIS_tvalid || M_AXIS_tready));
                end
            end
            if (S_AXIS_tready === 1'b1) begin
                fired = 1'b1;
                if (payload) in_cyc.push_back(cyc);
            end
            n++;
            if (!fired && n > 20) begin
                checks++; failures++;
                $display("FAIL s_tready_timeout: got no handshake in %0d cycles required <= 20", n);
                fired = 1'b1;
            end
            @(posedge ACLK);
            #1;
        end
        S_AXIS_tvalid = 1'b0;
        S_AXIS_tlast  = 1'b0;
    endtask

    task automatic send_frame(input logic [47:0] dest, input int nbeats, input logic [7:0] lkeep,
                              input int tag, input bit fwd);
        send_beat(hdr0(dest, c_SRC), 8'hFF, 1'b0, 1'b0);
        send_beat(hdr1(c_SRC, c_TYPE, c_SYNC), 8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < nbeats; i++)
            send_beat(pay(tag, i), (i == nbeats - 1) ? lkeep : 8'hFF, (i == nbeats - 1), fwd);
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        checks++;
        if (S_AXIS_tready !== 1'b0 || M_AXIS_tvalid !== 1'b0 || M_AXIS_tlast !== 1'b0) begin
            failures++;
            $display("FAIL reset_handshake: got s_rdy=%b m_vld=%b m_last=%b required 0 0 0",
                     S_AXIS_tready, M_AXIS_tvalid, M_AXIS_tlast);
        end
        checks++;
        if (M_AXIS_tdata !== 64'd0 || M_AXIS_tkeep !== 8'd0 || Rx_Source_Address !== 48'd0 ||
            Rx_Length !== 14'd0 || Rx_Done !== 1'b0 || Rx_Length_Error !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got data=%h keep=%h src=%h len=%0d done=%b err=%b required all 0",
                     M_AXIS_tdata, M_AXIS_tkeep, Rx_Source_Address, Rx_Length, Rx_Done, Rx_Length_Error);
        end
        checks++;
        if (Accept_Count !== 16'd0 || Drop_Count !== 16'd0) begin
            failures++;
            $display("FAIL reset_counters: got acc=%0d drop=%0d required 0 0", Accept_Count, Drop_Count);
        end
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        @(negedge ACLK);
        checks++;
        if (S_AXIS_tready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset: got %b required 1", S_AXIS_tready);
        end
        @(posedge ACLK); #1;
    endtask

    task automatic test_good_frame();
        clear_mon();
        Packet_Size = 14'd20;
        send_frame(c_LOCAL, 3, 8'h0F, 1, 1'b1);
        idle(8);
        exp_acc++;
        checks++;
        if (out_data.size() != 3) begin
            failures++;
            $display("FAIL good_beats: got %0d required 3", out_data.size());
        end
        for (int i = 0; i < out_data.size() && i < 3; i++) begin
            checks++;
            if (out_data[i] !== pay(1, i) || out_keep[i] !== ((i == 2) ? 8'h0F : 8'hFF) ||
                out_last[i] !== (i == 2)) begin
                failures++;
                $display("FAIL good_beat%0d: got %h/%h/%b required %h/%h/%b", i, out_data[i],
                         out_keep[i], out_last[i], pay(1, i), (i == 2) ? 8'h0F : 8'hFF, (i == 2));
            end
        end
        if (out_cyc.size() > 0 && in_cyc.size() > 0) begin
            checks++;
            if (out_cyc[0] - in_cyc[0] != 1) begin
                failures++;
                $display("FAIL good_latency: got %0d required 1", out_cyc[0] - in_cyc[0]);
            end
        end
        checks++;
        if (done_cnt != 1 || last_len !== 14'd20 || last_err !== 1'b0 || last_src !== c_SRC) begin
            failures++;
            $display("FAIL good_done: got n=%0d len=%0d err=%b src=%h required 1 20 0 %h",
                     done_cnt, last_len, last_err, last_src, c_SRC);
        end
        checks++;
        if (Accept_Count !== exp_acc[15:0] || Drop_Count !== exp_drop[15:0]) begin
            failures++;
            $display("FAIL good_counts: got acc=%0d drop=%0d required %0d %0d",
                     Accept_Count, Drop_Count, exp_acc, exp_drop);
        end
    endtask

    task automatic test_filter();
        int exp_beats;
`ifdef FRAME_PARSER_PROMISC_EN
        bit mis_fwd = 1'b1;
`else
        bit mis_fwd = 1'b0;
`endif
        clear_mon();
        send_frame(c_OTHER, 3, 8'h0F, 2, mis_fwd);
        idle(8);
        if (mis_fwd) exp_acc++; else exp_drop++;
        exp_beats = mis_fwd ? 3 : 0;
        checks++;
        if (out_data.size() != exp_beats || done_cnt != exp_beats / 3) begin
            failures++;
            $display("FAIL filter_mismatch: got beats=%0d done=%0d required %0d %0d",
                     out_data.size(), done_cnt, exp_beats, exp_beats / 3);
        end
        checks++;
        if (Accept_Count !== exp_acc[15:0] || Drop_Count !== exp_drop[15:0]) begin
            failures++;
            $display("FAIL filter_counts: got acc=%0d drop=%0d required %0d %0d",
                     Accept_Count, Drop_Count, exp_acc, exp_drop);
        end
        clear_mon();
        send_frame(c_BCAST, 3, 8'h0F, 3, 1'b1);
        idle(8);
        exp_acc++;
        checks++;
        if (out_data.size() != 3 || (out_data.size() == 3 && out_data[2] !== pay(3, 2))) begin
            failures++;
            $display("FAIL filter_broadcast: got beats=%0d required 3 ending %h", out_data.size(), pay(3, 2));
        end
        checks++;
        if (Accept_Count !== exp_acc[15:0]) begin
            failures++;
            $display("FAIL broadcast_acc: got %0d required %0d", Accept_Count, exp_acc);
        end
    endtask

    task automatic test_backpressure();
        clear_mon();
        Packet_Size = 14'd32;
        bp_mode = 1'b1;
        send_frame(c_LOCAL, 4, 8'hFF, 4, 1'b1);
        idle(10);
        bp_mode = 1'b0;
        idle(2);
        exp_acc++;
        checks++;
        if (out_data.size() != 4) begin
            failures++;
            $display("FAIL bp_beats: got %0d required 4", out_data.size());
        end
        for (int i = 0; i < out_data.size() && i < 4; i++) begin
            checks++;
            if (out_data[i] !== pay(4, i) || out_last[i] !== (i == 3)) begin
                failures++;
                $display("FAIL bp_beat%0d: got %h/%b required %h/%b", i, out_data[i], out_last[i],
                         pay(4, i), (i == 3));
            end
        end
        checks++;
        if (done_cnt != 1 || last_len !== 14'd32 || last_err !== 1'b0 || Accept_Count !== exp_acc[15:0]) begin
            failures++;
            $display("FAIL bp_done: got n=%0d len=%0d err=%b acc=%0d required 1 32 0 %0d",
                     done_cnt, last_len, last_err, Accept_Count, exp_acc);
        end
    endtask

    task automatic test_runts();
        clear_mon();
        Packet_Size = 14'd20;
        send_beat(hdr0(c_LOCAL, c_SRC), 8'hFF, 1'b1, 1'b0);
        send_beat(hdr0(c_LOCAL, c_SRC), 8'hFF, 1'b0, 1'b0);
        send_beat(hdr1(c_SRC, c_TYPE, c_SYNC), 8'hFF, 1'b1, 1'b0);
        idle(4);
        exp_drop += 2;
        checks++;
        if (out_data.size() != 0 || done_cnt != 0 || Drop_Count !== exp_drop[15:0]) begin
            failures++;
            $display("FAIL runts: got beats=%0d done=%0d drop=%0d required 0 0 %0d",
                     out_data.size(), done_cnt, Drop_Count, exp_drop);
        end
        send_frame(c_LOCAL, 3, 8'h0F, 5, 1'b1);
        idle(8);
        exp_acc++;
        checks++;
        if (out_data.size() != 3 || done_cnt != 1 || last_len !== 14'd20 ||
            Accept_Count !== exp_acc[15:0]) begin
            failures++;
            $display("FAIL after_runts: got beats=%0d done=%0d len=%0d acc=%0d required 3 1 20 %0d",
                     out_data.size(), done_cnt, last_len, Accept_Count, exp_acc);
        end
    endtask

    task automatic test_length_error();
        clear_mon();
        Packet_Size = 14'd24;
        send_frame(c_LOCAL, 3, 8'h0F, 6, 1'b1);
        idle(8);
        exp_acc++;
        checks++;
        if (done_cnt != 1 || last_len !== 14'd20 || last_err !== 1'b1 || err_alone != 0) begin
            failures++;
            $display("FAIL length_error: got n=%0d len=%0d err=%b stray=%0d required 1 20 1 0",
                     done_cnt, last_len, last_err, err_alone);
        end
        Packet_Size = 14'd20;
    endtask

    task automatic test_back_to_back();
        clear_mon();
        Packet_Size = 14'd12;
        bp_mode = 1'b1;
        send_frame(c_LOCAL, 2, 8'h0F, 7, 1'b1);
        send_frame(c_BCAST, 2, 8'h0F, 8, 1'b1);
        idle(10);
        bp_mode = 1'b0;
        idle(2);
        exp_acc += 2;
        checks++;
        if (out_data.size() != 4 || done_cnt != 2 || last_len !== 14'd12 || last_err !== 1'b0) begin
            failures++;
            $display("FAIL b2b_done: got beats=%0d done=%0d len=%0d err=%b required 4 2 12 0",
                     out_data.size(), done_cnt, last_len, last_err);
        end
        for (int i = 0; i < out_data.size() && i < 4; i++) begin
            checks++;
            if (out_data[i] !== pay(7 + i / 2, i % 2)) begin
                failures++;
                $display("FAIL b2b_beat%0d: got %h required %h", i, out_data[i], pay(7 + i / 2, i % 2));
            end
        end
        checks++;
        if (Accept_Count !== exp_acc[15:0] || Drop_Count !== exp_drop[15:0]) begin
            failures++;
            $display("FAIL b2b_counts: got acc=%0d drop=%0d required %0d %0d",
                     Accept_Count, Drop_Count, exp_acc, exp_drop);
        end
        Packet_Size = 14'd20;
    endtask

    task automatic test_reset_midframe();
        send_beat(hdr0(c_LOCAL, c_SRC), 8'hFF, 1'b0, 1'b0);
        send_beat(hdr1(c_SRC, c_TYPE, c_SYNC), 8'hFF, 1'b0, 1'b0);
        send_beat(pay(9, 0), 8'hFF, 1'b0, 1'b1);
        S_AXIS_tdata = pay(9, 1); S_AXIS_tkeep = 8'hFF; S_AXIS_tvalid = 1'b1;
        ARESET = 1'b1;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        checks++;
        if (M_AXIS_tvalid !== 1'b0 || M_AXIS_tdata !== 64'd0 || S_AXIS_tready !== 1'b0 ||
            Accept_Count !== 16'd0 || Drop_Count !== 16'd0 || Rx_Source_Address !== 48'd0) begin
            failures++;
            $display("FAIL midframe_reset: got vld=%b data=%h rdy=%b acc=%0d drop=%0d src=%h required all 0",
                     M_AXIS_tvalid, M_AXIS_tdata, S_AXIS_tready, Accept_Count, Drop_Count, Rx_Source_Address);
        end
        @(posedge ACLK); #1;
        S_AXIS_tvalid = 1'b0;
        ARESET = 1'b0;
        exp_acc = 0; exp_drop = 0;
        clear_mon();
        send_frame(c_LOCAL, 3, 8'h0F, 10, 1'b1);
        idle(8);
        exp_acc++;
        checks++;
        if (out_data.size() != 3 || done_cnt != 1 || last_len !== 14'd20 ||
            Accept_Count !== 16'd1 || Drop_Count !== 16'd0) begin
            failures++;
            $display("FAIL after_reset_frame: got beats=%0d done=%0d len=%0d acc=%0d drop=%0d required 3 1 20 1 0",
                     out_data.size(), done_cnt, last_len, Accept_Count, Drop_Count);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_filter();
        test_backpressure();
        test_runts();
        test_length_error();
        test_back_to_back();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
